branch_out_sequencer: RTL and testbench

Parametrised successor of the fixed three-output init/start state-machine test blocks emitted by the V# flow. It drives NUM_OUT registered output channels of WIDTH bits. On leaving reset it loads an initial ramp of values, then on each accepted condition word it loads one of two output vectors: the "true" vector when the condition is zero, otherwise the "false" vector. It adds a valid/ready handshake, an optional hold interval, one-shot/continuous mode and an update counter; it sits as a generic output stage for compiled FSM tests.

---
 rtl/branch_out_sequencer_pkg.sv | 18 +
 rtl/branch_out_sequencer_if.sv | 11 +
 rtl/branch_out_sequencer_hold_timer.sv | 27 ++
 rtl/branch_out_sequencer.sv | 104 ++++++++++
 tb/tb_branch_out_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_out_sequencer_pkg.sv
// Shared types and helpers for the branch-out output sequencer.
package branch_out_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_START = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Initial ramp value for channel k; the caller truncates to its channel width.
  function automatic logic [63:0] init_val(input int unsigned k,
                                           input int unsigned base,
                                           input int unsigned step);
    return 64'(base) + 64'(k) * 64'(step);
  endfunction

endpackage

// File: rtl/branch_out_sequencer_if.sv
// Condition-word valid/ready channel into the sequencer.
interface branch_out_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             cond_valid;
  logic [WIDTH-1:0] cond_data;
  logic             cond_ready;

  modport master (output cond_valid, output cond_data, input cond_ready);
  modport slave  (input cond_valid, input cond_data, output cond_ready);
endinterface

// File: rtl/branch_out_sequencer_hold_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);
  import branch_out_pkg::*;

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= CW'(HOLD_CYCLES - 1);
    else if (en && count != '0)
      count <= count - CW'(1);
  end

  assign done = (count == '0);
endmodule

// File: rtl/branch_out_sequencer.sv
// Output stage: init ramp, then condition-selected vector loads with optional hold.
module branch_out_sequencer #(
  parameter int          NUM_OUT     = 3,
  parameter int          WIDTH       = 32,
  parameter int unsigned INIT_BASE   = 10,
  parameter int unsigned INIT_STEP   = 10,
  parameter int          HOLD_CYCLES = 0,
  parameter int          MODE        = 1,
  parameter int          CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     restart,
  branch_out_sequencer_if.slave    cond,
  input  logic [NUM_OUT*WIDTH-1:0] val_true,
  input  logic [NUM_OUT*WIDTH-1:0] val_false,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         update_count,
  output logic [1:0]               fsm_state
);
  import branch_out_pkg::*;

  state_t                     state_q, state_d;
  logic [NUM_OUT*WIDTH-1:0]   out_d, init_vec;
  logic                       valid_d;
  logic [CNT_W-1:0]           cnt_d;
  logic                       ready, take, hold_done;

  assign ready           = (state_q == S_START);
  assign cond.cond_ready = ready;
  // restart wins over a simultaneous handshake, so the word is not consumed
  assign take            = cond.cond_valid && ready && !restart;

  always_comb begin
    init_vec = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++)
      init_vec[k*WIDTH +: WIDTH] = WIDTH'(init_val(k, INIT_BASE, INIT_STEP));
  end

  generate
    if (HOLD_CYCLES > 0) begin : g_hold
      hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .load  (take),
        .en    (state_q == S_HOLD),
        .done  (hold_done)
      );
    end else begin : g_no_hold
      assign hold_done = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    out_d   = out_data;
    valid_d = 1'b0;
    cnt_d   = update_count;
    unique case (state_q)
      S_INIT: begin
        out_d   = init_vec;
        state_d = S_START;
      end
      S_START: begin
        if (take) begin
          out_d   = (cond.cond_data == '0) ? val_true : val_false;
          valid_d = 1'b1;
          cnt_d   = update_count + CNT_W'(1);
          if (HOLD_CYCLES > 0)
            state_d = S_HOLD;
          else if (MODE == 0)
            state_d = S_DONE;
        end
      end
      S_HOLD: begin
        if (hold_done)
          state_d = (MODE == 0) ? S_DONE : S_START;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_INIT;
    endcase
    if (restart)
      state_d = S_INIT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_INIT;
      out_data     <= '0;
      out_valid    <= 1'b0;
      update_count <= '0;
    end else begin
      state_q      <= state_d;
      out_data     <= out_d;
      out_valid    <= valid_d;
      update_count <= cnt_d;
    end
  end

  assign fsm_state = state_q;
endmodule

// File: tb/tb_branch_out_sequencer.sv
// Four sequencer configurations driven in lockstep and checked against a behavioural model.
module tb_branch_out_sequencer;
  localparam int N = 4;
  localparam int HOLDS [N] = '{0, 3, 0, 2};
  localparam int MODES [N] = '{1, 1, 0, 1};
  localparam int CNTWS [N] = '{8, 8, 8, 2};
  localparam logic [95:0] INIT_VEC = {32'd30, 32'd20, 32'd10};

  logic        clk = 1'b0;
  logic        reset, restart, cond_valid;
  logic [31:0] cond_data;
  logic [95:0] val_true, val_false;

  logic [95:0] od  [N];
  logic        ov  [N];
  logic [7:0]  uc  [N];
  logic [1:0]  fsm [N];
  logic        rdy [N];

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 init, 1 accepting, 2 holding, 3 finished.
  int          m_phase [N];
  int          m_left  [N];
  int          m_cnt   [N];
  logic [95:0] m_out   [N];
  logic        m_valid [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = CNTWS[g];
    logic [CW-1:0] ucl;
    branch_out_sequencer_if #(.WIDTH(32)) cif ();
    assign cif.cond_valid = cond_valid;
    assign cif.cond_data  = cond_data;
    assign rdy[g]         = cif.cond_ready;
    assign uc[g]          = 8'(ucl);

    branch_out_sequencer #(
      .NUM_OUT(3), .WIDTH(32), .INIT_BASE(10), .INIT_STEP(10),
      .HOLD_CYCLES(HOLDS[g]), .MODE(MODES[g]), .CNT_W(CW)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .restart      (restart),
      .cond         (cif),
      .val_true     (val_true),
      .val_false    (val_false),
      .out_data     (od[g]),
      .out_valid    (ov[g]),
      .update_count (ucl),
      .fsm_state    (fsm[g])
    );
  end

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      if (!reset) begin
        m_phase[i] = 0; m_out[i] = '0; m_cnt[i] = 0; m_left[i] = 0;
      end else if (restart) begin
        if (m_phase[i] == 0) m_out[i] = INIT_VEC;
        m_phase[i] = 0;
      end else begin
        case (m_phase[i])
          0: begin m_out[i] = INIT_VEC; m_phase[i] = 1; end
          1: if (cond_valid) begin
               m_out[i]   = (cond_data == 0) ? val_true : val_false;
               m_valid[i] = 1'b1;
               m_cnt[i]++;
               if (HOLDS[i] > 0) begin m_phase[i] = 2; m_left[i] = HOLDS[i]; end
               else if (MODES[i] == 0) m_phase[i] = 3;
             end
          2: begin
               m_left[i]--;
               if (m_left[i] == 0) m_phase[i] = (MODES[i] != 0) ? 1 : 3;
             end
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; restart = 1'b0; cond_valid = 1'b0; cond_data = '0;
    val_true = '0; val_false = '0;
    repeat (3) cycle();
    for (int i = 0; i < N; i++) begin
      checks++; if (od[i] !== 96'd0) begin errors++; $display("FAIL reset_out dut%0d: got %h expected 0", i, od[i]); end
      checks++; if (ov[i] !== 1'b0) begin errors++; $display("FAIL reset_valid dut%0d: got %b expected 0", i, ov[i]); end
      checks++; if (fsm[i] !== 2'd0) begin errors++; $display("FAIL reset_state dut%0d: got %0d expected 0", i, fsm[i]); end
      checks++; if (uc[i] !== 8'd0) begin errors++; $display("FAIL reset_count dut%0d: got %0d expected 0", i, uc[i]); end
    end
    reset = 1'b1;
    cycle();
    for (int i = 0; i < N; i++) begin
      checks++; if (od[i] !== INIT_VEC) begin errors++; $display("FAIL init_out dut%0d: got %h expected %h", i, od[i], INIT_VEC); end
      checks++; if (fsm[i] !== 2'd1) begin errors++; $display("FAIL init_state dut%0d: got %0d expected 1", i, fsm[i]); end
      checks++; if (rdy[i] !== 1'b1) begin errors++; $display("FAIL init_ready dut%0d: got %b expected 1", i, rdy[i]); end
    end
  endtask

  task automatic test_basic();
    val_true  = {32'd1, 32'd3, 32'd1};
    val_false = {32'd7, 32'd5, 32'd2};
    cond_valid = 1'b1; cond_data = 32'd10;
    cycle();
    cond_valid = 1'b0;
    checks++; if (od[0] !== {32'd7, 32'd5, 32'd2}) begin errors++; $display("FAIL basic_false_out: got %h expected %h", od[0], {32'd7, 32'd5, 32'd2}); end
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL basic_valid_pulse: got %b expected 1", ov[0]); end
    checks++; if (uc[0] !== 8'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", uc[0]); end
    checks++; if (fsm[1] !== 2'd2) begin errors++; $display("FAIL basic_hold_entry: got %0d expected 2", fsm[1]); end
    checks++; if (fsm[2] !== 2'd3) begin errors++; $display("FAIL basic_oneshot_done: got %0d expected 3", fsm[2]); end
    cycle();
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", ov[0]); end
    cond_valid = 1'b1; cond_data = 32'd0;
    cycle();
    cond_valid = 1'b0;
    checks++; if (od[0] !== {32'd1, 32'd3, 32'd1}) begin errors++; $display("FAIL basic_true_out: got %h expected %h", od[0], {32'd1, 32'd3, 32'd1}); end
    checks++; if (uc[0] !== 8'd2) begin errors++; $display("FAIL basic_count2: got %0d expected 2", uc[0]); end
    checks++; if (od[1] !== m_out[1]) begin errors++; $display("FAIL basic_hold_out: got %h expected %h", od[1], m_out[1]); end
  endtask

  task automatic test_back_to_back();
    val_true  = {$urandom, $urandom, $urandom};
    val_false = {$urandom, $urandom, $urandom};
    for (int k = 0; k < 5; k++) begin
      cond_valid = 1'b1;
      cond_data  = (k % 2 == 1) ? ($urandom | 32'd1) : 32'd0;
      cycle();
      checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL b2b_valid k%0d: got %b expected 1", k, ov[0]); end
      checks++; if (od[0] !== ((k % 2 == 1) ? val_false : val_true)) begin
        errors++; $display("FAIL b2b_out k%0d: got %h expected %h", k, od[0], (k % 2 == 1) ? val_false : val_true);
      end
    end
    cond_valid = 1'b0;
    checks++; if (uc[0] !== 8'd7) begin errors++; $display("FAIL b2b_count: got %0d expected 7", uc[0]); end
    cycle();
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL b2b_valid_idle: got %b expected 0", ov[0]); end
  endtask

  task automatic test_hold();
    int n, base;
    n = 0;
    while (rdy[1] !== 1'b1 && n < 20) begin cycle(); n++; end
    checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL hold_wait_ready: got %b expected 1 within 20 cycles", rdy[1]); end
    base = m_cnt[1];
    cond_valid = 1'b1; cond_data = $urandom;
    cycle();
    n = 0;
    while (rdy[1] === 1'b0 && n < 10) begin n++; cycle(); end
    checks++; if (n !== 3) begin errors++; $display("FAIL hold_ready_low_cycles: got %0d expected 3", n); end
    checks++; if (uc[1] !== 8'(base + 1)) begin errors++; $display("FAIL hold_no_accept: got %0d expected %0d", uc[1], base + 1); end
    cond_valid = 1'b0;
  endtask

  task automatic test_one_shot();
    int c0;
    cond_valid = 1'b1; cond_data = 32'd0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++; if (fsm[2] !== 2'd3) begin errors++; $display("FAIL oneshot_state k%0d: got %0d expected 3", k, fsm[2]); end
      checks++; if (rdy[2] !== 1'b0) begin errors++; $display("FAIL oneshot_ready k%0d: got %b expected 0", k, rdy[2]); end
    end
    c0 = m_cnt[0];
    restart = 1'b1;
    cycle();
    restart = 1'b0; cond_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++; if (fsm[i] !== 2'd0) begin errors++; $display("FAIL restart_state dut%0d: got %0d expected 0", i, fsm[i]); end
    end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL restart_beats_hs_valid: got %b expected 0", ov[0]); end
    checks++; if (uc[0] !== 8'(c0)) begin errors++; $display("FAIL restart_beats_hs_count: got %0d expected %0d", uc[0], c0); end
    cycle();
    checks++; if (od[2] !== INIT_VEC) begin errors++; $display("FAIL restart_init_out: got %h expected %h", od[2], INIT_VEC); end
    checks++; if (fsm[2] !== 2'd1) begin errors++; $display("FAIL restart_start: got %0d expected 1", fsm[2]); end
    checks++; if (uc[2] !== 8'd1) begin errors++; $display("FAIL restart_keeps_count: got %0d expected 1", uc[2]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      reset      = ($urandom_range(0, 49) != 0);
      restart    = ($urandom_range(0, 19) == 0);
      cond_valid = $urandom_range(0, 1);
      cond_data  = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) val_true  = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) val_false = {$urandom, $urandom, $urandom};
      cycle();
      for (int i = 0; i < N; i++) begin
        checks++; if (od[i] !== m_out[i]) begin errors++; $display("FAIL rnd_out dut%0d cyc%0d: got %h expected %h", i, c, od[i], m_out[i]); end
        checks++; if (ov[i] !== m_valid[i]) begin errors++; $display("FAIL rnd_valid dut%0d cyc%0d: got %b expected %b", i, c, ov[i], m_valid[i]); end
        checks++; if (uc[i] !== 8'(m_cnt[i] & ((1 << CNTWS[i]) - 1))) begin
          errors++; $display("FAIL rnd_count dut%0d cyc%0d: got %0d expected %0d", i, c, uc[i], m_cnt[i] & ((1 << CNTWS[i]) - 1));
        end
        checks++; if (fsm[i] !== 2'(m_phase[i])) begin errors++; $display("FAIL rnd_state dut%0d cyc%0d: got %0d expected %0d", i, c, fsm[i], m_phase[i]); end
        checks++; if (rdy[i] !== (m_phase[i] == 1)) begin errors++; $display("FAIL rnd_ready dut%0d cyc%0d: got %b expected %b", i, c, rdy[i], m_phase[i] == 1); end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int n;
    reset = 1'b1; restart = 1'b0; cond_valid = 1'b0;
    n = 0;
    while (rdy[1] !== 1'b1 && n < 20) begin cycle(); n++; end
    checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL midhold_wait_ready: got %b expected 1 within 20 cycles", rdy[1]); end
    cond_valid = 1'b1; cond_data = 32'd5;
    cycle();
    checks++; if (fsm[1] !== 2'd2) begin errors++; $display("FAIL midhold_in_hold: got %0d expected 2", fsm[1]); end
    reset = 1'b0; restart = 1'b1;
    cycle();
    for (int i = 0; i < N; i++) begin
      checks++; if (od[i] !== 96'd0) begin errors++; $display("FAIL midhold_out dut%0d: got %h expected 0", i, od[i]); end
      checks++; if (fsm[i] !== 2'd0) begin errors++; $display("FAIL midhold_state dut%0d: got %0d expected 0", i, fsm[i]); end
      checks++; if (ov[i] !== 1'b0) begin errors++; $display("FAIL midhold_valid dut%0d: got %b expected 0", i, ov[i]); end
      checks++; if (uc[i] !== 8'd0) begin errors++; $display("FAIL midhold_count dut%0d: got %0d expected 0", i, uc[i]); end
    end
    reset = 1'b1; restart = 1'b0; cond_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    cycle();
    cond_valid = 1'b1; cond_data = $urandom;
    n = 0;
    while (m_cnt[3] < 5 && n < 60) begin cycle(); n++; end
    cond_valid = 1'b0;
    checks++; if (uc[3] !== 8'd1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", uc[3]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_one_shot();
    test_random();
    test_reset_mid_hold();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
